// File: rtl/ly_pulse_compress.sv
// ly_pulse_compress: stretched hit pulses -> single-cycle leading-edge pulses with per-bit dead time
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   deadtime      : dead-time length loaded into a bit's counter when it fires
//   in            : stretched hit inputs
//   out, fire_any : registered one-clock pulses per bit and their OR
//   cnt_clear     : synchronous clear of suppress_cnt
//   suppress_cnt  : saturating count of cycles with at least one suppressed edge
module ly_pulse_compress #(
  parameter int WIDTH  = 224,
  parameter bit BYPASS = 1'b0,
  parameter int CNTW   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       deadtime,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             fire_any,
  input  logic             cnt_clear,
  output logic [CNTW-1:0]  suppress_cnt
);
  logic [WIDTH-1:0] in_q, out_q, out_d, rise, busy, fire, supp;
  logic [3:0]       dead_q [WIDTH];
  logic [3:0]       dead_d [WIDTH];
  logic             fire_any_q, fire_any_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  always_comb begin
    rise = in & ~in_q;
    for (int i = 0; i < WIDTH; i++) busy[i] = dead_q[i] != 4'd0;
    fire = rise & ~busy;
    supp = rise & busy;
    // suppressed edges never reload: the dead time is non-retriggerable
    for (int i = 0; i < WIDTH; i++) dead_d[i] = fire[i] ? deadtime : busy[i] ? dead_q[i] - 4'd1 : 4'd0;
    out_d = fire;
    fire_any_d = |fire;
    cnt_d = cnt_clear ? '0 : (|supp && cnt_q != '1) ? cnt_q + CNTW'(1) : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q <= '0;
      out_q <= '0;
      fire_any_q <= 1'b0;
      cnt_q <= '0;
      for (int i = 0; i < WIDTH; i++) dead_q[i] <= 4'd0;
    end else begin
      in_q <= in;
      out_q <= out_d;
      fire_any_q <= fire_any_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < WIDTH; i++) dead_q[i] <= dead_d[i];
    end
  end
  assign out = BYPASS ? in : out_q;
  assign fire_any = BYPASS ? |in : fire_any_q;
  assign suppress_cnt = cnt_q;
endmodule

// File: tb/tb_ly_pulse_compress.sv
// tb_ly_pulse_compress: directed + model-checked bench for ly_pulse_compress
module tb_ly_pulse_compress;
  localparam int W = 224;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [3:0] dt = 4'd0;
  logic [W-1:0] din = '0, out;
  logic fire_any;
  logic [15:0] cnt;
  logic [7:0] sin = '0, sout, bin = '0, bout;
  logic sclr = 1'b0, sfa, bfa;
  logic [3:0] scnt, bcnt;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  ly_pulse_compress #(.WIDTH(W), .BYPASS(1'b0), .CNTW(16)) dut (
    .clock(clk), .reset(rst), .deadtime(dt), .in(din), .out(out),
    .fire_any(fire_any), .cnt_clear(clr), .suppress_cnt(cnt));
  ly_pulse_compress #(.WIDTH(8), .BYPASS(1'b0), .CNTW(4)) sat (
    .clock(clk), .reset(rst), .deadtime(4'd15), .in(sin), .out(sout),
    .fire_any(sfa), .cnt_clear(sclr), .suppress_cnt(scnt));
  ly_pulse_compress #(.WIDTH(8), .BYPASS(1'b1), .CNTW(4)) byp (
    .clock(clk), .reset(rst), .deadtime(4'd4), .in(bin), .out(bout),
    .fire_any(bfa), .cnt_clear(1'b0), .suppress_cnt(bcnt));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: a bit may fire on a rising edge only once (deadtime at last fire)+1 cycles have elapsed.
  logic [W-1:0] m_prev, m_out;
  logic m_fa = 1'b0;
  int m_cnt = 0, cyc = 0;
  int m_last [W];
  int m_dt [W];
  always @(posedge clk) begin
    logic [W-1:0] f;
    bit s;
    f = '0;
    s = 1'b0;
    if (rst) begin
      m_prev = '0;
      m_cnt = 0;
      for (int i = 0; i < W; i++) begin m_last[i] = -100; m_dt[i] = 0; end
    end else begin
      for (int i = 0; i < W; i++)
        if (din[i] && !m_prev[i]) begin
          if (cyc >= m_last[i] + m_dt[i] + 1) begin f[i] = 1'b1; m_last[i] = cyc; m_dt[i] = int'(dt); end
          else s = 1'b1;
        end
      m_prev = din;
      m_cnt = clr ? 0 : (s && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    end
    m_out = f;
    m_fa = |f;
    cyc++;
  end

  always @(negedge clk) begin
    chk("model_out", out, m_out);
    chk("model_fire_any", fire_any, m_fa);
    chk("model_cnt", cnt, m_cnt[15:0]);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [W-1:0] e;
    int n;
    rst = 1'b1;
    step(); step();
    chk("reset_out", out, 0);
    chk("reset_fa", fire_any, 0);
    chk("reset_cnt", cnt, 0);
    rst = 1'b0;
    step();
    // single-cycle pulse, deadtime 0
    din[5] = 1'b1;
    step();
    e = '0; e[5] = 1'b1;
    chk("t1_out", out, e);
    chk("t1_fa", fire_any, 1);
    din[5] = 1'b0;
    step();
    chk("t1_out_after", out, 0);
    // stretched input produces one pulse
    dt = 4'd3;
    repeat (3) step();
    din[0] = 1'b1;
    n = 0;
    repeat (6) begin step(); n += int'(out[0]); end
    din[0] = 1'b0;
    step(); n += int'(out[0]);
    chk("t2_pulses", n, 1);
    chk("t2_cnt", cnt, 0);
    // re-rise inside dead time is suppressed
    repeat (5) step();
    din[0] = 1'b1; step();
    chk("t3_first", out[0], 1);
    din[0] = 1'b0; step();
    din[0] = 1'b1; step();
    din[0] = 1'b0; step();
    chk("t3_supp_out", out[0], 0);
    chk("t3_cnt", cnt, 1);
    // re-rise at t+4 fires
    repeat (5) step();
    din[0] = 1'b1; step();
    din[0] = 1'b0; step(); step(); step();
    din[0] = 1'b1; step();
    chk("t3b_fire", out[0], 1);
    chk("t3b_cnt", cnt, 1);
    din[0] = 1'b0;
    repeat (5) step();
    // two bits suppressed in one cycle count once
    dt = 4'd2;
    din[1] = 1'b1; din[200] = 1'b1; step();
    e = '0; e[1] = 1'b1; e[200] = 1'b1;
    chk("t4_out", out, e);
    din[1] = 1'b0; din[200] = 1'b0; step();
    din[1] = 1'b1; din[200] = 1'b1; step();
    din[1] = 1'b0; din[200] = 1'b0; step();
    chk("t4_out_supp", out, 0);
    chk("t4_cnt", cnt, 2);
    // clear coinciding with a suppression wins
    repeat (5) step();
    din[3] = 1'b1; step();
    din[3] = 1'b0; step();
    din[3] = 1'b1; clr = 1'b1; step();
    din[3] = 1'b0; clr = 1'b0; step();
    chk("t5_clr_cnt", cnt, 0);
    // mixed traffic with changing deadtime, checked by the model
    repeat (300) begin
      din[15:0] = 16'($urandom);
      dt = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 29) == 0);
      step();
    end
    din = '0; clr = 1'b0;
    repeat (20) step();
    // held input across reset fires once after reset
    dt = 4'd4;
    din[7] = 1'b1;
    repeat (3) step();
    rst = 1'b1; step(); step();
    chk("t6_reset_out", out, 0);
    rst = 1'b0; step();
    e = '0; e[7] = 1'b1;
    chk("t6_fire", out, e);
    n = 0;
    repeat (10) begin step(); n += int'(out[7]); end
    chk("t6_no_more", n, 0);
    din[7] = 1'b0;
    // saturation on a narrow counter
    chk("sat_start", scnt, 0);
    repeat (200) begin sin[0] = ~sin[0]; step(); end
    chk("sat_full", scnt, 15);
    sin = '0;
    repeat (20) step();
    sin[0] = 1'b1; step();
    chk("sat_fire", sout[0], 1);
    sin[0] = 1'b0; step();
    sin[0] = 1'b1; sclr = 1'b1; step();
    sin[0] = 1'b0; sclr = 1'b0; step();
    chk("sat_clr", scnt, 0);
    // bypass is combinational
    bin = 8'hA5; #1;
    chk("byp_out", bout, 8'hA5);
    chk("byp_fa", bfa, 1);
    bin = 8'h00; #1;
    chk("byp_out0", bout, 8'h00);
    chk("byp_fa0", bfa, 0);
    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ly_pulse_compress.md
Name: ly_pulse_compress

Overview:
- Per-bit converter from stretched layer-hit pulses back to single-cycle leading-edge pulses, with a non-retriggerable dead time per bit.
- Performs the inverse of the layer one-shot stretcher in the pattern_finder path.
- Used where downstream logic (hit counters, rate monitors, DAQ hit packing) must count each hit once regardless of its persistence width.
- Provides a saturating counter of cycles in which any edge was suppressed by dead time, for rate diagnostics.

Parameters:
- WIDTH, 224, number of independent hit bits (one per layer half-strip).
- BYPASS, 0, if 1 then out is combinationally equal to in, and fire_any equals the OR of in; all internal state still runs.
- CNTW, 16, width of the suppression counter.

Ports:
- clock  input  1  main clock; all logic is synchronous to its rising edge.
- reset  input  1  synchronous, active-high reset.
- deadtime  input  4  dead-time length in clocks after an emitted pulse; sampled on the cycle of each fire.
- in  input  WIDTH  stretched hit inputs, one per bit.
- out  output  WIDTH  single-cycle leading-edge pulses, registered.
- fire_any  output  1  registered OR of all fire bits; aligned with out.
- cnt_clear  input  1  synchronous clear of suppress_cnt.
- suppress_cnt  output  CNTW  saturating count of cycles with at least one suppressed edge.

Behaviour:
- Reset values: in_ff=0, dead_cnt[i]=0 for all bits, out=0, fire_any=0, suppress_cnt=0.
- Per-bit signals, with in_ff[i] being in[i] registered every clock (no enable):
  - rise[i] = in[i] & ~in_ff[i]
  - busy[i] = (dead_cnt[i] != 0)
  - fire[i] = rise[i] & ~busy[i]
  - supp[i] = rise[i] & busy[i]
- Dead-time counter, in priority order:
  - reset -> 0
  - else fire[i] -> load deadtime[3:0]
  - else busy[i] -> dead_cnt[i]-1
  - else hold 0
- Non-retriggerable: a rise during busy is counted as suppressed, does not reload the counter, and is lost permanently.
  - Because in_ff tracks in unconditionally, a suppressed input that stays high does not fire when dead time expires.
- Output timing (BYPASS=0):
  - out[i] <= fire[i] and fire_any <= |fire, giving a latency of 1 clock from the rising edge of in.
  - The out pulse is exactly 1 clock wide.
- deadtime=0: no dead time, so every rising edge fires. Minimum re-fire spacing is 2 clocks (edge, low, edge).
- deadtime=N (1..15): the counter is busy for N clocks after the fire cycle. The earliest next fire is a rising edge N+1 clocks after the previous fire.
- deadtime changing mid-operation affects only subsequent loads; running counters are not altered.
- Input held high for any duration produces exactly one pulse.
- suppress_cnt, in priority order:
  - reset or cnt_clear -> 0
  - else if |supp and suppress_cnt != all-ones -> +1
  - saturates at 2^CNTW-1.
  - Multiple suppressed bits in the same cycle increment the count by only 1.
  - If cnt_clear and |supp coincide, the result is 0.
- Reset mid-operation:
  - All counters and in_ff clear.
  - A bit that is high on the first cycle after reset deasserts is seen as a rising edge and fires.
- Bits are fully independent; no cross-bit interaction except fire_any and suppress_cnt.

Test Plan:
- Reset release, deadtime=0, in[5] pulsed high for 1 clk at cycle t -> out[5]=1 only at t+1 and fire_any=1 at t+1; all other out bits stay 0.
- deadtime=3, in[0] stretched high for 6 clks starting at t -> exactly one out[0] pulse at t+1; suppress_cnt stays 0.
- deadtime=3, in[0] rises at t, falls at t+1, rises again at t+2 -> second edge suppressed, only out[0] at t+1, suppress_cnt=1. Repeat with second rise at t+4 -> fires at t+5, suppress_cnt unchanged.
- deadtime=2, in[1] and in[200] rise at t, both fall at t+1, both rise again at t+2 -> out[1] and out[200] at t+1, both suppressed at t+2, suppress_cnt increments by 1 only.
- Force 70000 suppressed cycles (deadtime=15, toggling input) -> suppress_cnt saturates at 0xFFFF. Then assert cnt_clear together with a suppression -> suppress_cnt=0.
- in[7] held high through a reset pulse, deadtime=4 -> out[7]=1 one clock after the reset-deassert cycle, with no further pulses while in[7] stays high. Separately, with BYPASS=1: out equals in in the same cycle.
